spi_slave: RTL and testbench
============================

# spi_slave

Receive-side SPI endpoint, mode 0 (CPOL=0, CPHA=0), MSB first, 16-bit frames; it is the responder for the team's `spi_master`. All SPI pins are oversampled in the `sys_clk` domain (50 MHz) through synchronizers, so no logic is clocked by `spi_clk`. Each frame delivers one received word with a single-cycle valid strobe and shifts one preloaded word back out on `spi_miso`. The block sits between the board SPI pins and user logic, for register-access or loopback links.

## Interface
Parameters:
- `DATA_W`, 16: frame length in bits; also the width of `tx_data` and `rx_data`.
- `SYNC_STAGES`, 2: flip-flop depth of each input synchronizer; minimum 2.

Ports:
- `sys_clk`, in, 1: system clock, 50 MHz; all logic is clocked on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `spi_csn`, in, 1: chip select from the master, active low.
- `spi_clk`, in, 1: SPI clock from the master; idles low.
- `spi_mosi`, in, 1: data from the master.
- `spi_miso`, out, 1: data to the master; always driven, never tristated.
- `tx_data`, in, DATA_W: word to send in the next frame.
- `tx_load`, in, 1: one-cycle strobe that captures `tx_data` into `tx_buf`.
- `rx_data`, out, DATA_W: last complete received word.
- `rx_valid`, out, 1: one-cycle pulse when `rx_data` updates.
- `frame_err`, out, 1: one-cycle pulse when CS deasserts mid-word.
- `busy`, out, 1: high while a frame is active.

## Operation
- **Synchronizers.** Each of `spi_clk`, `spi_csn` and `spi_mosi` passes through SYNC_STAGES flops.
  - Reset values: `spi_clk` 0, `spi_csn` 1, `spi_mosi` 0.
  - One further register per synced clock/CS feeds the edge detectors: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- **State machine**, two states:
  - IDLE → ACTIVE on `cs_fall`. On that cycle:
    - `tx_shift` <= `tx_buf`, or `tx_data` directly if `tx_load` is high in the same cycle.
    - `bit_cnt` <= 0.
  - ACTIVE → IDLE on `cs_rise`.
  - ACTIVE, on `sclk_rise`:
    - `rx_shift` <= {`rx_shift`[DATA_W-2:0], synced mosi}.
    - `bit_cnt` <= `bit_cnt` + 1.
  - ACTIVE, on `sclk_fall`: `tx_shift` <= {`tx_shift`[DATA_W-2:0], 0}.
  - `sclk_rise`/`sclk_fall` are ignored in IDLE.
- **Word completion.** On the `sclk_rise` that makes `bit_cnt` reach DATA_W:
  - `rx_data` <= completed word, including the bit sampled that cycle.
  - `rx_valid` = 1 on the next cycle.
  - `bit_cnt` <= 0.
  - A flag is set so that the next `sclk_fall` reloads `tx_shift` from `tx_buf` instead of shifting. This allows back-to-back words under one CS.
- **MISO.** `spi_miso` is registered.
  - It equals `tx_shift`[DATA_W-1] while ACTIVE.
  - It is 0 in IDLE.
- **tx_buf.**
  - Written by `tx_load` at any time.
  - A load during a frame affects only the next word.
  - Without a new load, the previous word is resent.
- **CS deasserted mid-word.** On `cs_rise` with `bit_cnt` != 0:
  - `frame_err` pulses for 1 cycle.
  - The partial word is discarded; `rx_data` is unchanged and there is no `rx_valid`.
- **CS deasserted cleanly.** On `cs_rise` with `bit_cnt` == 0: no error.
- **busy** = (state == ACTIVE).
- **Reset values of outputs:** `spi_miso` 0, `rx_data` 0, `rx_valid` 0, `frame_err` 0, `busy` 0. Internal state returns to IDLE and `tx_buf` clears to 0.
- **Reset mid-frame** aborts immediately. No `rx_valid` or `frame_err` is generated for the aborted frame.

## Timing
- Pin edge to detected edge: SYNC_STAGES+1 `sys_clk` cycles (3 at default).
- `spi_clk` falling pin edge to `spi_miso` change: SYNC_STAGES+2 cycles (4 at default).
- Last `spi_clk` rise to `rx_valid`: SYNC_STAGES+2 cycles.
- Constraints on the master:
  - `spi_clk` high and low phases are each ≥ 6 `sys_clk` cycles.
  - CS falling edge to first `spi_clk` rise is ≥ 6 cycles.
  - The team master's 25-cycle half period satisfies both.
- `cs_fall` and `cs_rise` take priority over a `spi_clk` edge detected in the same cycle. A `spi_clk` edge coincident with `cs_rise` is dropped.
- `rx_valid` and `frame_err` are never high in the same cycle.

## Configuration
- Macro: `SPI_SLAVE_LOOPBACK_EN`.
- **Defined:** at every word completion, `tx_buf` <= the received word, so the next word echoes it. If `tx_load` occurs in the same cycle, `tx_load` wins.
- **Undefined:** `tx_buf` is written only by `tx_load`.

## Test plan
- **Basic receive.** After reset, one frame with MOSI = 16'hA55A at 25-cycle half period → exactly one `rx_valid` with `rx_data` = 16'hA55A; `busy` is high only inside CS.
- **Transmit.** `tx_load` with `tx_data` = 16'h3C81 before CS falls → the master samples 16'h3C81 on MISO. A second frame with no reload → 16'h3C81 again.
- **Back-to-back words.** Two words, 16'h1234 then 16'hFEDC, under one CS → two `rx_valid` pulses with the correct data, and no `frame_err`.
- **Aborted frame.** CS rises after 7 bits → `frame_err` pulses once, `rx_data` keeps its previous value, and a following full frame of 16'h0F0F is received correctly.
- **Reset mid-frame.** `rst_n` is asserted after 10 bits → all outputs read 0 immediately, and the next full frame of 16'hFFFF is received correctly.
- **Loopback.** With `SPI_SLAVE_LOOPBACK_EN` defined, frame 1 carries MOSI = 16'hBEEF → frame 2 returns 16'hBEEF on MISO.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, MSB-first DATA_W-bit frames.
// Define SPI_SLAVE_LOOPBACK_EN to echo each received word in the next one.
module spi_slave #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              spi_csn,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] clk_sr, csn_sr, mosi_sr;
    logic sclk_s, csn_s, mosi_s;
    logic sclk_d, csn_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [DATA_W-1:0] tx_buf, tx_shift, rx_shift, rx_word;
    logic [CNT_W-1:0] bit_cnt;
    logic reload, done_q;
    logic start, stop, rise_en, fall_en, word_done;

    assign sclk_s = clk_sr[SYNC_STAGES-1];
    assign csn_s  = csn_sr[SYNC_STAGES-1];
    assign mosi_s = mosi_sr[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~csn_s & csn_d;
    assign cs_rise   = csn_s & ~csn_d;

    assign rx_word = {rx_shift[DATA_W-2:0], mosi_s};
    assign busy    = (state == ACTIVE);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr  <= '0;
            csn_sr  <= '1;
            mosi_sr <= '0;
            sclk_d  <= 1'b0;
            csn_d   <= 1'b1;
        end else begin
            clk_sr  <= {clk_sr[SYNC_STAGES-2:0], spi_clk};
            csn_sr  <= {csn_sr[SYNC_STAGES-2:0], spi_csn};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            sclk_d  <= sclk_s;
            csn_d   <= csn_s;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // CS edges win over a coincident clock edge, which is then dropped.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        stop       = 1'b0;
        rise_en    = 1'b0;
        fall_en    = 1'b0;
        word_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    next_state = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    next_state = IDLE;
                    stop       = 1'b1;
                end else begin
                    rise_en   = sclk_rise;
                    fall_en   = sclk_fall;
                    word_done = sclk_rise && (bit_cnt == LAST);
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf <= '0;
        end else if (tx_load) begin
            tx_buf <= tx_data;
`ifdef SPI_SLAVE_LOOPBACK_EN
        end else if (word_done) begin
            tx_buf <= rx_word;
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '0;
            reload   <= 1'b0;
        end else if (start) begin
            tx_shift <= tx_load ? tx_data : tx_buf;
            reload   <= 1'b0;
        end else if (word_done) begin
            reload <= 1'b1;
        end else if (fall_en) begin
            // First falling edge after a full word starts the next word.
            tx_shift <= reload ? tx_buf : {tx_shift[DATA_W-2:0], 1'b0};
            reload   <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else if (start || word_done) begin
            rx_shift <= word_done ? rx_word : rx_shift;
            bit_cnt  <= '0;
        end else if (rise_en) begin
            rx_shift <= rx_word;
            bit_cnt  <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            done_q    <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            spi_miso  <= 1'b0;
        end else begin
            if (word_done) rx_data <= rx_word;
            done_q    <= word_done;
            rx_valid  <= done_q;
            frame_err <= stop && (bit_cnt != '0);
            spi_miso  <= (state == ACTIVE) ? tx_shift[DATA_W-1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged mode-0 master with a receive scoreboard.
// Build with SPI_SLAVE_LOOPBACK_EN to also exercise the echo path.
module tb_spi_slave;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] tx_data = '0;
    logic        tx_load = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    int total = 0;
    int bad = 0;
    int ferr_cnt = 0;
    int rxv_cnt = 0;
    int rx_pushed = 0;
    logic [15:0] rxq[$];
    logic [15:0] exp_buf = '0;

    spi_slave #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .spi_csn  (spi_csn),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (frame_err) ferr_cnt++;
            if (rx_valid) begin
                rxv_cnt++;
                check("rxv_ferr", 32'(frame_err), 32'd0);
                if (rxq.size() == 0)
                    check("rx_extra", 32'(rxq.size()), 32'd1);
                else
                    check("rx_data", 32'(rx_data), 32'(rxq.pop_front()));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic load(input logic [15:0] v);
        @(negedge sys_clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge sys_clk);
        tx_load = 1'b0;
        exp_buf = v;
    endtask

    task automatic cs_low();
        @(negedge sys_clk);
        spi_csn = 1'b0;
        wait_cyc(10);
        check("busy_in", 32'(busy), 32'd1);
    endtask

    task automatic cs_high();
        wait_cyc(25);
        spi_csn = 1'b1;
        wait_cyc(10);
        check("busy_out", 32'(busy), 32'd0);
    endtask

    task automatic word(input logic [15:0] mo, input int nbits);
        logic [15:0] got;
        logic [15:0] exp_mi;
        got    = '0;
        exp_mi = exp_buf;
        if (nbits == 16) begin
            rxq.push_back(mo);
            rx_pushed++;
        end
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[15-i];
            wait_cyc(25);
            spi_clk = 1'b1;
            got[15-i] = spi_miso;
            wait_cyc(25);
            spi_clk = 1'b0;
        end
        if (nbits == 16) begin
            check("miso", 32'(got), 32'(exp_mi));
`ifdef SPI_SLAVE_LOOPBACK_EN
            exp_buf = mo;
`endif
        end
    endtask

    initial begin
        int f0;
        wait_cyc(3);
        #1;
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        cs_low();
        word(16'hA55A, 16);
        cs_high();

        load(16'h3C81);
        cs_low();
        word(16'h1111, 16);
        cs_high();
        cs_low();
        word(16'h2222, 16);
        cs_high();

        f0 = ferr_cnt;
        cs_low();
        word(16'h1234, 16);
        word(16'hFEDC, 16);
        cs_high();
        check("b2b_ferr", 32'(ferr_cnt), 32'(f0));

        f0 = ferr_cnt;
        cs_low();
        word(16'h5555, 7);
        cs_high();
        check("abort_ferr", 32'(ferr_cnt), 32'(f0 + 1));
        check("abort_keep", 32'(rx_data), 32'h0000_FEDC);
        cs_low();
        word(16'h0F0F, 16);
        cs_high();

        f0 = ferr_cnt;
        cs_low();
        word(16'hAAAA, 10);
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check("mid_miso", 32'(spi_miso), 32'd0);
        check("mid_rx_data", 32'(rx_data), 32'd0);
        check("mid_rx_valid", 32'(rx_valid), 32'd0);
        check("mid_frame_err", 32'(frame_err), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        spi_csn = 1'b1;
        exp_buf = '0;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(10);
        check("mid_no_ferr", 32'(ferr_cnt), 32'(f0));
        cs_low();
        word(16'hFFFF, 16);
        cs_high();

`ifdef SPI_SLAVE_LOOPBACK_EN
        cs_low();
        word(16'hBEEF, 16);
        cs_high();
        cs_low();
        word(16'h0000, 16);
        cs_high();
`endif

        wait_cyc(50);
        check("rx_pending", 32'(rxq.size()), 32'd0);
        check("rx_count", 32'(rxv_cnt), 32'(rx_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
